// File: rtl/exec_hazard_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : exec_hazard_unit_if
// Purpose  : Bundles every non-clock/non-reset signal of the execute-stage
//            hazard block: ALU operands and result, target adder, register
//            specifiers from D/E/M/W, hazard control outputs and the
//            registered E->M values.
// Ports    : (interface signals)
//            a, b, aluctr          -> ALU operands / operation select
//            aluout, iszero        <- combinational ALU result / zero flag
//            add_a, add_b, add_y   -> / <- target adder
//            ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
//            memtoregE, regwriteM, regwriteW, controlChange -> hazard inputs
//            stallF, stallD, flushD, flushE, forwardAE, forwardBE <- hazards
//            aluout_m, cc_m        <- registered E->M boundary
//            stall_cnt, flush_cnt  <- only when HAZ_STATS_EN is defined
// Modports : master (pipeline/driver side), slave (exec_hazard_unit side)
// Config   : HAZ_STATS_EN adds the stall/flush statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
interface exec_hazard_unit_if #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      aluctr;
  logic [XLEN-1:0] aluout;
  logic            iszero;

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] add_y;

  logic [4:0]      ra1D;
  logic [4:0]      ra2D;
  logic [4:0]      ra1E;
  logic [4:0]      ra2E;
  logic [4:0]      rdE;
  logic [4:0]      rdM;
  logic [4:0]      rdW;
  logic            memtoregE;
  logic            regwriteM;
  logic            regwriteW;
  logic            controlChange;

  logic            stallF;
  logic            stallD;
  logic            flushD;
  logic            flushE;
  logic [1:0]      forwardAE;
  logic [1:0]      forwardBE;

  logic [XLEN-1:0] aluout_m;
  logic            cc_m;

`ifdef HAZ_STATS_EN
  logic [31:0]     stall_cnt;
  logic [31:0]     flush_cnt;

  modport master (
    output a, b, aluctr, add_a, add_b,
    output ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
    output memtoregE, regwriteM, regwriteW, controlChange,
    input  aluout, iszero, add_y,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
    input  aluout_m, cc_m,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  a, b, aluctr, add_a, add_b,
    input  ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
    input  memtoregE, regwriteM, regwriteW, controlChange,
    output aluout, iszero, add_y,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
    output aluout_m, cc_m,
    output stall_cnt, flush_cnt
  );
`else
  modport master (
    output a, b, aluctr, add_a, add_b,
    output ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
    output memtoregE, regwriteM, regwriteW, controlChange,
    input  aluout, iszero, add_y,
    input  stallF, stallD, flushD, flushE, forwardAE, forwardBE,
    input  aluout_m, cc_m
  );

  modport slave (
    input  a, b, aluctr, add_a, add_b,
    input  ra1D, ra2D, ra1E, ra2E, rdE, rdM, rdW,
    input  memtoregE, regwriteM, regwriteW, controlChange,
    output aluout, iszero, add_y,
    output stallF, stallD, flushD, flushE, forwardAE, forwardBE,
    output aluout_m, cc_m
  );
`endif

endinterface : exec_hazard_unit_if
`default_nettype wire

// File: rtl/exec_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_hazard_unit
// Purpose  : Execute-stage core of a 5-stage RV32I pipeline. Holds the ALU,
//            the branch/jump target adder and the hazard unit (forwarding
//            selects, load-use stall, control-change flush). The ALU result
//            and the control-change flag are registered into the E->M
//            boundary.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous, active-low reset (clears E->M registers
//                     and statistics counters only)
//            bus    - exec_hazard_unit_if.slave, carrying operands, register
//                     specifiers, hazard controls and the registered outputs
// Config   : HAZ_STATS_EN - when defined, bus.stall_cnt counts cycles with a
//            load-use stall and bus.flush_cnt counts cycles with a resolved
//            control change. Both wrap at 2^32. When undefined, the counters
//            do not exist and everything else is identical.
// Revision : 1.0 - initial release
// ============================================================================
module exec_hazard_unit #(
  parameter int XLEN = 32
) (
  input  wire                     clk,
  input  wire                     reset,
  exec_hazard_unit_if.slave       bus
);

  // --------------------------------------------------------------------------
  // ALU operation encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_SLL  = 4'd2;
  localparam logic [3:0] c_OP_SLT  = 4'd3;
  localparam logic [3:0] c_OP_SLTU = 4'd4;
  localparam logic [3:0] c_OP_XOR  = 4'd5;
  localparam logic [3:0] c_OP_SRL  = 4'd6;
  localparam logic [3:0] c_OP_SRA  = 4'd7;
  localparam logic [3:0] c_OP_OR   = 4'd8;
  localparam logic [3:0] c_OP_AND  = 4'd9;
  localparam logic [3:0] c_OP_PASSB = 4'd10;

  // Forwarding select encoding
  localparam logic [1:0] c_FWD_REGFILE = 2'b00;
  localparam logic [1:0] c_FWD_RESULTW = 2'b01;
  localparam logic [1:0] c_FWD_ALUOUTM = 2'b10;

  localparam logic [XLEN-1:0] c_ZERO = '0;

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] w_aluResult;
  logic [4:0]      w_shamt;
  logic            w_ltSigned;
  logic            w_ltUnsigned;

  assign w_shamt      = bus.b[4:0];
  assign w_ltSigned   = ($signed(bus.a) < $signed(bus.b));
  assign w_ltUnsigned = (bus.a < bus.b);

  always_comb begin
    w_aluResult = c_ZERO;
    case (bus.aluctr)
      c_OP_ADD:   w_aluResult = bus.a + bus.b;
      c_OP_SUB:   w_aluResult = bus.a - bus.b;
      c_OP_SLL:   w_aluResult = bus.a << w_shamt;
      c_OP_SLT:   w_aluResult = {{(XLEN-1){1'b0}}, w_ltSigned};
      c_OP_SLTU:  w_aluResult = {{(XLEN-1){1'b0}}, w_ltUnsigned};
      c_OP_XOR:   w_aluResult = bus.a ^ bus.b;
      c_OP_SRL:   w_aluResult = bus.a >> w_shamt;
      // Arithmetic shift must see a signed operand, otherwise >>> fills zeros.
      c_OP_SRA:   w_aluResult = $unsigned($signed(bus.a) >>> w_shamt);
      c_OP_OR:    w_aluResult = bus.a | bus.b;
      c_OP_AND:   w_aluResult = bus.a & bus.b;
      c_OP_PASSB: w_aluResult = bus.b;
      // Unused encodings 11..15 deliberately yield zero (and so iszero=1).
      default:    w_aluResult = c_ZERO;
    endcase
  end

  assign bus.aluout = w_aluResult;
  assign bus.iszero = (w_aluResult == c_ZERO);

  // --------------------------------------------------------------------------
  // Target adder: plain modular sum, carry-out dropped.
  // --------------------------------------------------------------------------
  assign bus.add_y = bus.add_a + bus.add_b;

  // --------------------------------------------------------------------------
  // Forwarding
  // The M-stage producer is younger than the W-stage one, so it is checked
  // first. x0 is never forwarded because its architectural value is always 0.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwdSelect(
    input logic [4:0] srcE,
    input logic       regwriteM,
    input logic [4:0] rdM,
    input logic       regwriteW,
    input logic [4:0] rdW
  );
    logic [1:0] sel;
    sel = c_FWD_REGFILE;
    if (regwriteM && (rdM != 5'd0) && (rdM == srcE)) begin
      sel = c_FWD_ALUOUTM;
    end else if (regwriteW && (rdW != 5'd0) && (rdW == srcE)) begin
      sel = c_FWD_RESULTW;
    end
    return sel;
  endfunction

  logic [1:0] w_forwardA;
  logic [1:0] w_forwardB;

  assign w_forwardA = fwdSelect(bus.ra1E, bus.regwriteM, bus.rdM,
                                bus.regwriteW, bus.rdW);
  assign w_forwardB = fwdSelect(bus.ra2E, bus.regwriteM, bus.rdM,
                                bus.regwriteW, bus.rdW);

  assign bus.forwardAE = w_forwardA;
  assign bus.forwardBE = w_forwardB;

  // --------------------------------------------------------------------------
  // Load-use stall and control-change flush
  // A load in E cannot forward its data to the instruction in D in time, so
  // F and D hold while E receives a bubble. A redirect squashes D and E; when
  // both happen together the flushes dominate in the datapath, but the stall
  // outputs still report the load-use condition.
  // --------------------------------------------------------------------------
  logic w_lwStall;

  assign w_lwStall = bus.memtoregE && (bus.rdE != 5'd0) &&
                     ((bus.rdE == bus.ra1D) || (bus.rdE == bus.ra2D));

  assign bus.stallF = w_lwStall;
  assign bus.stallD = w_lwStall;
  assign bus.flushD = bus.controlChange;
  assign bus.flushE = w_lwStall | bus.controlChange;

  // --------------------------------------------------------------------------
  // E->M boundary registers. This stage is never stalled, so no enable.
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] r_aluoutM;
  logic            r_ccM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aluoutM <= c_ZERO;
      r_ccM     <= 1'b0;
    end else begin
      r_aluoutM <= w_aluResult;
      r_ccM     <= bus.controlChange;
    end
  end

  assign bus.aluout_m = r_aluoutM;
  assign bus.cc_m     = r_ccM;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef HAZ_STATS_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCnt <= 32'd0;
      r_flushCnt <= 32'd0;
    end else begin
      if (w_lwStall) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
      if (bus.controlChange) begin
        r_flushCnt <= r_flushCnt + 32'd1;
      end
    end
  end

  assign bus.stall_cnt = r_stallCnt;
  assign bus.flush_cnt = r_flushCnt;
`else
`endif

endmodule : exec_hazard_unit
`default_nettype wire

// File: tb/tb_exec_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_hazard_unit
// Purpose  : Self-checking bench for exec_hazard_unit. Directed steps push
//            their expected outputs into a scoreboard queue while driving
//            stimulus; the queue is drained and compared once the outputs
//            have settled, away from the rising clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_hazard_unit;

  localparam int XLEN = 32;

  // Output selectors used by the scoreboard
  localparam int c_SEL_ALUOUT = 0;
  localparam int c_SEL_ISZERO = 1;
  localparam int c_SEL_ADDY   = 2;
  localparam int c_SEL_FWDA   = 3;
  localparam int c_SEL_FWDB   = 4;
  localparam int c_SEL_STALLF = 5;
  localparam int c_SEL_STALLD = 6;
  localparam int c_SEL_FLUSHD = 7;
  localparam int c_SEL_FLUSHE = 8;
  localparam int c_SEL_ALUM   = 9;
  localparam int c_SEL_CCM    = 10;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t sbq[$];

  exec_hazard_unit_if #(.XLEN(XLEN)) bus ();

  exec_hazard_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      c_SEL_ALUOUT: return bus.aluout;
      c_SEL_ISZERO: return {31'd0, bus.iszero};
      c_SEL_ADDY:   return bus.add_y;
      c_SEL_FWDA:   return {30'd0, bus.forwardAE};
      c_SEL_FWDB:   return {30'd0, bus.forwardBE};
      c_SEL_STALLF: return {31'd0, bus.stallF};
      c_SEL_STALLD: return {31'd0, bus.stallD};
      c_SEL_FLUSHD: return {31'd0, bus.flushD};
      c_SEL_FLUSHE: return {31'd0, bus.flushE};
      c_SEL_ALUM:   return bus.aluout_m;
      c_SEL_CCM:    return {31'd0, bus.cc_m};
      default:      return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input int sel, input logic [31:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = v;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.a = '0; bus.b = '0; bus.aluctr = 4'd0;
    bus.add_a = '0; bus.add_b = '0;
    bus.ra1D = 5'd0; bus.ra2D = 5'd0; bus.ra1E = 5'd0; bus.ra2E = 5'd0;
    bus.rdE = 5'd0; bus.rdM = 5'd0; bus.rdW = 5'd0;
    bus.memtoregE = 1'b0; bus.regwriteM = 1'b0; bus.regwriteW = 1'b0;
    bus.controlChange = 1'b0;
  endtask

  task automatic alu_step(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] ctr, input logic [31:0] expY,
                          input logic expZ, input string tag);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.aluctr = ctr;
    expect_out(c_SEL_ALUOUT, expY, {tag, "_aluout"});
    expect_out(c_SEL_ISZERO, {31'd0, expZ}, {tag, "_iszero"});
    #1 check_all();
  endtask

  task automatic hazard_expect(input logic sF, input logic sD,
                               input logic fD, input logic fE, input string tag);
    expect_out(c_SEL_STALLF, {31'd0, sF}, {tag, "_stallF"});
    expect_out(c_SEL_STALLD, {31'd0, sD}, {tag, "_stallD"});
    expect_out(c_SEL_FLUSHD, {31'd0, fD}, {tag, "_flushD"});
    expect_out(c_SEL_FLUSHE, {31'd0, fE}, {tag, "_flushE"});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();

    // Reset state; combinational paths stay live while reset is asserted.
    bus.a = 32'd5; bus.b = 32'd7;
    repeat (2) @(posedge clk);
    #1;
    expect_out(c_SEL_ALUM, 32'd0, "rst_aluout_m");
    expect_out(c_SEL_CCM, 32'd0, "rst_cc_m");
    expect_out(c_SEL_ALUOUT, 32'd12, "rst_comb_add");
    check_all();
    @(negedge clk);
    reset = 1'b1;

    // ALU
    alu_step(32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE, 1'b0, "sub_neg");
    alu_step(32'h8000_0000, 32'd1, 4'd3, 32'd1, 1'b0, "slt_signed");
    alu_step(32'h8000_0000, 32'd1, 4'd4, 32'd0, 1'b1, "sltu");
    alu_step(32'h8000_0000, 32'd4, 4'd7, 32'hF800_0000, 1'b0, "sra");
    alu_step(32'h8000_0000, 32'd4, 4'd6, 32'h0800_0000, 1'b0, "srl");
    alu_step(32'd9, 32'd9, 4'd1, 32'd0, 1'b1, "sub_zero");
    alu_step(32'h1234_5678, 32'h0000_0024, 4'd2, 32'h2345_6780, 1'b0, "sll_b40");
    alu_step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd5, 32'hFF00_FF00, 1'b0, "xor");
    alu_step(32'hF0F0_0000, 32'h0000_0F0F, 4'd8, 32'hF0F0_0F0F, 1'b0, "or");
    alu_step(32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9, 32'h00F0_00F0, 1'b0, "and");
    alu_step(32'hAAAA_AAAA, 32'hABCD_E000, 4'd10, 32'hABCD_E000, 1'b0, "passb");
    alu_step(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1, "add_wrap");
    alu_step(32'h1234_5678, 32'h1111_1111, 4'd12, 32'd0, 1'b1, "op12");
    alu_step(32'h1234_5678, 32'h1111_1111, 4'd15, 32'd0, 1'b1, "op15");

    // Target adder wraps
    @(negedge clk);
    bus.add_a = 32'hFFFF_FFFC; bus.add_b = 32'd8;
    expect_out(c_SEL_ADDY, 32'h0000_0004, "adder_wrap");
    #1 check_all();

    // Forwarding: M beats W
    @(negedge clk);
    bus.regwriteM = 1'b1; bus.rdM = 5'd3;
    bus.regwriteW = 1'b1; bus.rdW = 5'd3;
    bus.ra1E = 5'd3; bus.ra2E = 5'd4;
    expect_out(c_SEL_FWDA, 32'd2, "fwdA_m_prio");
    expect_out(c_SEL_FWDB, 32'd0, "fwdB_nomatch");
    #1 check_all();

    @(negedge clk);
    bus.regwriteM = 1'b0;
    expect_out(c_SEL_FWDA, 32'd1, "fwdA_w");
    #1 check_all();

    @(negedge clk);
    bus.regwriteM = 1'b1; bus.rdM = 5'd7; bus.rdW = 5'd4;
    bus.ra1E = 5'd7;
    expect_out(c_SEL_FWDA, 32'd2, "fwdA_m_only");
    expect_out(c_SEL_FWDB, 32'd1, "fwdB_w");
    #1 check_all();

    // x0 is never forwarded
    @(negedge clk);
    bus.rdM = 5'd0; bus.rdW = 5'd0; bus.ra1E = 5'd0; bus.ra2E = 5'd0;
    expect_out(c_SEL_FWDA, 32'd0, "fwdA_x0");
    expect_out(c_SEL_FWDB, 32'd0, "fwdB_x0");
    #1 check_all();

    // Load-use
    @(negedge clk);
    idle_inputs();
    bus.memtoregE = 1'b1; bus.rdE = 5'd5; bus.ra2D = 5'd5; bus.ra1D = 5'd6;
    hazard_expect(1'b1, 1'b1, 1'b0, 1'b1, "lw_ra2");
    #1 check_all();

    @(negedge clk);
    bus.ra2D = 5'd9; bus.ra1D = 5'd5;
    hazard_expect(1'b1, 1'b1, 1'b0, 1'b1, "lw_ra1");
    #1 check_all();

    @(negedge clk);
    bus.rdE = 5'd0; bus.ra1D = 5'd0; bus.ra2D = 5'd0;
    hazard_expect(1'b0, 1'b0, 1'b0, 1'b0, "lw_x0");
    #1 check_all();

    @(negedge clk);
    bus.memtoregE = 1'b0; bus.rdE = 5'd5; bus.ra1D = 5'd5;
    hazard_expect(1'b0, 1'b0, 1'b0, 1'b0, "notload");
    #1 check_all();

    // Load-use and redirect together
    @(negedge clk);
    bus.memtoregE = 1'b1; bus.controlChange = 1'b1;
    hazard_expect(1'b1, 1'b1, 1'b1, 1'b1, "lw_and_cc");
    #1 check_all();

    // Branch taken, plus registered capture of aluout
    @(negedge clk);
    idle_inputs();
    bus.controlChange = 1'b1;
    bus.a = 32'h0000_1234; bus.b = 32'd0; bus.aluctr = 4'd0;
    hazard_expect(1'b0, 1'b0, 1'b1, 1'b1, "branch");
    #1 check_all();
    @(posedge clk);
    #1;
    expect_out(c_SEL_CCM, 32'd1, "branch_cc_m");
    expect_out(c_SEL_ALUM, 32'h0000_1234, "aluout_m_cap");
    check_all();

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    expect_out(c_SEL_ALUM, 32'd0, "async_rst_aluout_m");
    expect_out(c_SEL_CCM, 32'd0, "async_rst_cc_m");
    expect_out(c_SEL_ALUOUT, 32'h0000_1234, "async_rst_comb");
    check_all();

    // Capture resumes after release
    @(negedge clk);
    reset = 1'b1;
    bus.controlChange = 1'b0;
    bus.a = 32'h0000_0100; bus.b = 32'h0000_0001; bus.aluctr = 4'd1;
    @(posedge clk);
    #1;
    expect_out(c_SEL_ALUM, 32'h0000_00FF, "post_rst_cap");
    expect_out(c_SEL_CCM, 32'd0, "post_rst_cc_m");
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_exec_hazard_unit
`default_nettype wire
